operand_fetch: RTL
==================

# operand_fetch

Operand fetch stage between the address generator and the systolic array. Takes paired A/B read requests (enable, commit flag, byte-granular read address) each cycle, issues them to two single-port operand SRAMs with 1-cycle read latency, and unpacks returned words per datatype. Buffers paired A/B operands in a small FIFO under a valid/ready handshake toward the array edge. Flags protocol errors.

## Interface
- AW, 12, SRAM word-address width
- DEPTH, 4, output FIFO depth in entries (power of two, ≥2)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous drop of FIFO contents and in-flight reads
- datatype  in  2  operand type from shared params package (FP32, FP16, INT8, INT4), sampled with en_A
- en_A / en_B  in  1  read request valid for A / B
- cmen_A / cmen_B  in  1  commit (accumulate-end) flag travelling with request
- rdaddr_A / rdaddr_B  in  32  request address; bit 0 = halfword select, bits [AW:1] = SRAM word address
- sram_rd_en_A / sram_rd_en_B  out  1  SRAM read strobe
- sram_rd_addr_A / sram_rd_addr_B  out  AW  SRAM word address
- sram_rd_data_A / sram_rd_data_B  in  32  SRAM read data, valid the cycle after strobe
- op_valid  out  1  FIFO head valid
- op_ready  in  1  array accepts head
- op_A / op_B  out  32  unpacked operands at head
- op_cmen  out  1  commit flag at head (from cmen_A)
- op_count  out  $clog2(DEPTH+1)  FIFO occupancy
- err_overflow  out  1  sticky: return data arrived with FIFO full and no pop
- err_pair  out  1  sticky: en_A != en_B, or cmen_A != cmen_B while enabled

## Operation
- Request issue (combinational): sram_rd_en_X = en_X & ~flush; sram_rd_addr_X = rdaddr_X[AW:1].
- Tag stage (registered, 1 deep): valid = en_A & en_B & ~flush, plus datatype, cmen_A, rdaddr_A[0], rdaddr_B[0].
- Return cycle: if tag valid, push unpacked pair into FIFO.
- Unpack per tagged datatype, independently for A and B:
  - FP32: word unchanged.
  - FP16: half-select 0 → {16'h0, data[15:0]}; 1 → {16'h0, data[31:16]}.
  - INT8, INT4: word unchanged (lanes packed; lane split in array).
- FIFO: circular, DEPTH entries, write/read pointers wrap modulo DEPTH; op_valid = (count != 0); pop = op_valid & op_ready.
- Push when full: if pop same cycle, push accepted; else pushed entry dropped, FIFO unchanged, err_overflow set.
- Pairing: mismatched enables or commit flags set err_pair; pair not pushed (tag valid requires both enables); SRAM strobes still follow individual enables.
- flush: clears tag valid, pointers, count; returning data of the flushed request discarded; error flags unaffected.
- Errors clear only on rst.

## Timing
- Reset values: sram_rd_en_* = 0 (en inputs expected low), sram_rd_addr_* = rdaddr passthrough, op_valid 0, op_count 0, op_A/op_B/op_cmen 0, err_* 0, tag valid 0.
- Latency: en at cycle t → SRAM data at t+1 → entry pushed at edge ending t+1 → op_valid high in t+2.
- Throughput: one pair per cycle with op_ready held high.
- op_A/op_B/op_cmen stable while op_valid & ~op_ready.
- Simultaneous push and pop with count = 0: impossible (op_valid 0); count becomes 1.
- Simultaneous push and pop otherwise: count unchanged.
- rst or flush mid-burst: next cycle empty; requests issued in the flush cycle are not strobed.

## Test plan
- FP32: SRAM A[5]=32'hDEADBEEF, B[5]=32'h01234567; en_A=en_B=1, rdaddr_A=rdaddr_B=10 at t → op_valid at t+2, op_A=DEADBEEF, op_B=01234567.
- FP16: word 3 = 32'hABCD1234; rdaddr_A=7, rdaddr_B=6 → op_A=0000ABCD, op_B=00001234.
- Backpressure: op_ready=0, 5 consecutive requests, DEPTH=4 → op_count 4, err_overflow=1 at t+5, head = first request; release op_ready → 4 pops in order.
- Full with pop: count=4, op_ready=1, continuous requests → count stays 4, err_overflow stays 0, order preserved.
- Flush: 2 requests issued, flush in cycle of return of first → count 0 next cycle, op_valid 0, no later push.
- Pair error: en_A=1, en_B=0 for one cycle → sram_rd_en_A=1, err_pair=1, no FIFO push; only rst clears err_pair.

Source files
------------

// File: rtl/operand_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : operand_fetch_if
//  Purpose  : Request, SRAM and array-edge signals of the operand fetch stage.
//             master = address generator / SRAM / array side, slave = stage.
//  Revision : 1.0  initial release
// ============================================================================
interface operand_fetch_if #(
  parameter int AW    = 12,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  // request side
  logic          flush;
  logic [1:0]    datatype;
  logic          en_A;
  logic          en_B;
  logic          cmen_A;
  logic          cmen_B;
  logic [31:0]   rdaddr_A;
  logic [31:0]   rdaddr_B;

  // SRAM side
  logic          sram_rd_en_A;
  logic          sram_rd_en_B;
  logic [AW-1:0] sram_rd_addr_A;
  logic [AW-1:0] sram_rd_addr_B;
  logic [31:0]   sram_rd_data_A;
  logic [31:0]   sram_rd_data_B;

  // array edge and status
  logic          op_valid;
  logic          op_ready;
  logic [31:0]   op_A;
  logic [31:0]   op_B;
  logic          op_cmen;
  logic [CW-1:0] op_count;
  logic          err_overflow;
  logic          err_pair;

  modport master (
    output flush, datatype, en_A, en_B, cmen_A, cmen_B, rdaddr_A, rdaddr_B,
    output sram_rd_data_A, sram_rd_data_B, op_ready,
    input  sram_rd_en_A, sram_rd_en_B, sram_rd_addr_A, sram_rd_addr_B,
    input  op_valid, op_A, op_B, op_cmen, op_count, err_overflow, err_pair
  );

  modport slave (
    input  flush, datatype, en_A, en_B, cmen_A, cmen_B, rdaddr_A, rdaddr_B,
    input  sram_rd_data_A, sram_rd_data_B, op_ready,
    output sram_rd_en_A, sram_rd_en_B, sram_rd_addr_A, sram_rd_addr_B,
    output op_valid, op_A, op_B, op_cmen, op_count, err_overflow, err_pair
  );
endinterface
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : operand_fetch
//  Purpose  : Issues paired A/B operand SRAM reads, tags them for the 1-cycle
//             read latency, unpacks returned words per datatype and buffers
//             the pairs in a small FIFO toward the systolic array edge.
//             Sticky flags report FIFO overflow and unpaired requests.
//  Revision : 1.0  initial release
// ============================================================================
module operand_fetch #(
  parameter int AW    = 12,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  operand_fetch_if.slave     bus
);

  // datatype encoding shared with the params package: FP32=0 FP16=1 INT8=2 INT4=3
  localparam logic [1:0] c_dt_fp16 = 2'd1;
  localparam int         c_ptr_w   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         c_cnt_w   = $clog2(DEPTH + 1);
  localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);

  // tag stage: describes the read whose data returns this cycle
  logic         r_tag_valid;
  logic [1:0]   r_tag_dt;
  logic         r_tag_cmen;
  logic         r_tag_hs_a;
  logic         r_tag_hs_b;

  // FIFO storage and bookkeeping; entry = {cmen, A, B}
  logic [64:0]        r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               r_err_overflow;
  logic               r_err_pair;

  logic        w_valid;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_pair_bad;
  logic [31:0] w_unp_a;
  logic [31:0] w_unp_b;
  logic [64:0] w_head;

  // address bits above the SRAM word range are intentionally ignored
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{bus.rdaddr_A[31:AW+1], bus.rdaddr_B[31:AW+1]};

  // FP16 picks one halfword and zero-extends; other types pass the word whole
  function automatic logic [31:0] f_unpack(input logic [1:0]  dt,
                                           input logic        hs,
                                           input logic [31:0] word);
    if (dt == c_dt_fp16) begin
      return hs ? {16'h0, word[31:16]} : {16'h0, word[15:0]};
    end
    return word;
  endfunction

  // request issue is combinational so data lands exactly one cycle later
  assign bus.sram_rd_en_A   = bus.en_A & ~bus.flush;
  assign bus.sram_rd_en_B   = bus.en_B & ~bus.flush;
  assign bus.sram_rd_addr_A = bus.rdaddr_A[AW:1];
  assign bus.sram_rd_addr_B = bus.rdaddr_B[AW:1];

  assign w_pair_bad = (bus.en_A ^ bus.en_B) |
                      (bus.en_A & bus.en_B & (bus.cmen_A ^ bus.cmen_B));

  // capture the request attributes needed to unpack the returning words
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_valid <= 1'b0;
      r_tag_dt    <= 2'd0;
      r_tag_cmen  <= 1'b0;
      r_tag_hs_a  <= 1'b0;
      r_tag_hs_b  <= 1'b0;
    end else begin
      r_tag_valid <= bus.en_A & bus.en_B & ~bus.flush;
      r_tag_dt    <= bus.datatype;
      r_tag_cmen  <= bus.cmen_A;
      r_tag_hs_a  <= bus.rdaddr_A[0];
      r_tag_hs_b  <= bus.rdaddr_B[0];
    end
  end

  // unpack both returning SRAM words using the tagged datatype
  always_comb begin
    w_unp_a = f_unpack(r_tag_dt, r_tag_hs_a, bus.sram_rd_data_A);
    w_unp_b = f_unpack(r_tag_dt, r_tag_hs_b, bus.sram_rd_data_B);
  end

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == c_full_cnt);
  assign w_pop   = w_valid & bus.op_ready;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign w_push  = r_tag_valid & ~bus.flush & (~w_full | w_pop);

  // FIFO storage write; pointers are cleared separately so no reset needed
  always_ff @(posedge clk) begin
    if (w_push & ~rst) begin
      r_mem[r_wr_ptr] <= {r_tag_cmen, w_unp_a, w_unp_b};
    end
  end

  // pointer and occupancy update; flush empties the FIFO in one cycle
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // sticky protocol error flags; only reset clears them, flush does not
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_overflow <= 1'b0;
      r_err_pair     <= 1'b0;
    end else begin
      if (r_tag_valid & ~bus.flush & w_full & ~w_pop) r_err_overflow <= 1'b1;
      if (w_pair_bad) r_err_pair <= 1'b1;
    end
  end

  // head outputs read as zero while the FIFO is empty
  assign w_head           = r_mem[r_rd_ptr];
  assign bus.op_valid     = w_valid;
  assign bus.op_cmen      = w_valid & w_head[64];
  assign bus.op_A         = w_valid ? w_head[63:32] : 32'h0;
  assign bus.op_B         = w_valid ? w_head[31:0]  : 32'h0;
  assign bus.op_count     = r_count;
  assign bus.err_overflow = r_err_overflow;
  assign bus.err_pair     = r_err_pair;

endmodule
`default_nettype wire
